qspi_sram_responder: RTL

QSPI_SRAM_RESPONDER -- requirements
Module: qspi_sram_responder

---
 rtl/qspi_sram_responder.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/qspi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : qspi_sram_responder
// Purpose  : Quad-SPI SRAM target. It decodes 0xEB (quad read) and 0x38
//            (quad write) followed by a 24-bit address and serves a 2^AW byte
//            internal memory. Read data is preceded by WAIT_CYC dummy sck
//            cycles. Any other command is flagged on cmd_err and ignored.
//            sck, ce_n and sio_i are oversampled in the clk domain.
// Ports    : clk     - system clock
//            rst     - asynchronous active-high reset
//            sck     - serial clock from the initiator
//            ce_n    - chip enable, active-low
//            sio_i   - quad data from the initiator
//            sio_o   - quad data to the initiator
//            sio_oe  - high while sio_o is driven
//            cmd_err - one-clk pulse on an unsupported command
// Revision : 1.0 - initial release
// ============================================================================
module qspi_sram_responder #(
  parameter int AW       = 12,
  parameter int WAIT_CYC = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic       sio_oe,
  output logic       cmd_err
);

  // The counter is shared by the command (2), address (6) and dummy phases.
  localparam int         c_cnt_w     = $clog2(WAIT_CYC + 8);
  localparam int         c_wait_last = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;
  localparam logic [7:0] c_cmd_read  = 8'hEB;
  localparam logic [7:0] c_cmd_write = 8'h38;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_WAIT   = 3'd3,
    S_RDATA  = 3'd4,
    S_WDATA  = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic               r_s1_sck;
  logic               r_s1_ce_n;
  logic [3:0]         r_s1_sio;
  logic               r_s2_sck;
  logic               r_armed;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_half;
  logic [AW-1:0]      r_addr;
  logic [3:0]         r_cmd_hi;
  logic               r_is_rd;
  logic [3:0]         r_wr_hi;
  logic [7:0]         r_wr_byte;
  logic               r_wr_pend;

  logic [7:0]         r_mem [0:(1<<AW)-1];

  logic               w_rise;
  logic               w_fall;
  logic [7:0]         w_cmd_byte;
  logic               w_cmd_ok;
  logic               w_cmd_done;
  logic               w_addr_done;
  logic               w_wait_done;
  logic [7:0]         w_rd_byte;

  assign w_rise      = r_s1_sck & ~r_s2_sck;
  assign w_fall      = ~r_s1_sck & r_s2_sck;
  assign w_cmd_byte  = {r_cmd_hi, r_s1_sio};
  assign w_cmd_ok    = (w_cmd_byte == c_cmd_read) || (w_cmd_byte == c_cmd_write);
  assign w_cmd_done  = (r_state == S_CMD)  && w_rise && (r_cnt == c_cnt_w'(1));
  assign w_addr_done = (r_state == S_ADDR) && w_rise && (r_cnt == c_cnt_w'(5));
  assign w_wait_done = (r_state == S_WAIT) && w_rise && (r_cnt == c_cnt_w'(c_wait_last));
  // Asynchronous read: a write that lands before the fetching sck fall is
  // returned directly, with no bypass path needed.
  assign w_rd_byte   = r_mem[r_addr];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    if (r_s1_ce_n) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (r_armed) w_next = S_CMD;
        S_CMD:    if (w_cmd_done) w_next = w_cmd_ok ? S_ADDR : S_IGNORE;
        S_ADDR: begin
          if (w_addr_done) begin
            if (!r_is_rd)          w_next = S_WDATA;
            else if (WAIT_CYC > 0) w_next = S_WAIT;
            else                   w_next = S_RDATA;
          end
        end
        S_WAIT:   if (w_wait_done) w_next = S_RDATA;
        S_RDATA:  w_next = S_RDATA;
        S_WDATA:  w_next = S_WDATA;
        S_IGNORE: w_next = S_IGNORE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Input sampling and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_sck  <= 1'b0;
      r_s1_ce_n <= 1'b1;
      r_s1_sio  <= 4'h0;
      r_s2_sck  <= 1'b0;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_half    <= 1'b0;
      r_addr    <= '0;
      r_cmd_hi  <= 4'h0;
      r_is_rd   <= 1'b0;
      r_wr_hi   <= 4'h0;
      r_wr_byte <= 8'h00;
      r_wr_pend <= 1'b0;
      sio_o     <= 4'h0;
      sio_oe    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      r_s1_sck  <= sck;
      r_s1_ce_n <= ce_n;
      r_s1_sio  <= sio_i;
      r_s2_sck  <= r_s1_sck;
      // Only a real high sample of ce_n (not the reset value of the s1
      // stage) may arm the first transaction after reset.
      r_armed   <= r_armed | ce_n;
      cmd_err   <= 1'b0;

      // A fully received byte is committed even if ce_n rises right after.
      if (r_wr_pend) begin
        r_wr_pend <= 1'b0;
        r_addr    <= r_addr + 1'b1;
      end

      if (r_s1_ce_n) begin
        r_cnt  <= '0;
        r_half <= 1'b0;
        sio_oe <= 1'b0;
        sio_o  <= 4'h0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt  <= '0;
            r_half <= 1'b0;
          end
          S_CMD: begin
            if (w_rise) begin
              r_cmd_hi <= r_s1_sio;
              r_cnt    <= r_cnt + 1'b1;
              if (w_cmd_done) begin
                r_cnt   <= '0;
                r_is_rd <= (w_cmd_byte == c_cmd_read);
                cmd_err <= !w_cmd_ok;
              end
            end
          end
          S_ADDR: begin
            if (w_rise) begin
              // Shifting 6 nibbles keeps only the low AW address bits.
              r_addr <= (r_addr << 4) | AW'(r_s1_sio);
              r_cnt  <= w_addr_done ? '0 : r_cnt + 1'b1;
            end
          end
          S_WAIT: begin
            if (w_rise) r_cnt <= r_cnt + 1'b1;
          end
          S_RDATA: begin
            if (w_fall) begin
              sio_oe <= 1'b1;
              if (!r_half) begin
                sio_o  <= w_rd_byte[7:4];
                r_half <= 1'b1;
              end else begin
                sio_o  <= w_rd_byte[3:0];
                r_half <= 1'b0;
                r_addr <= r_addr + 1'b1;
              end
            end
          end
          S_WDATA: begin
            if (w_rise) begin
              if (!r_half) begin
                r_wr_hi <= r_s1_sio;
                r_half  <= 1'b1;
              end else begin
                r_wr_byte <= {r_wr_hi, r_s1_sio};
                r_wr_pend <= 1'b1;
                r_half    <= 1'b0;
              end
            end
          end
          default: begin
            r_cnt  <= '0;
            r_half <= 1'b0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Memory array (deliberately not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r_wr_pend && !rst) begin
      r_mem[r_addr] <= r_wr_byte;
    end
  end

endmodule
`default_nettype wire
